// File: rtl/change_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// change_dispense_ctrl
//
// Pays out change after a vend. The owed amount is broken into coins
// greedily (25c, then 10c, then 5c). The controller asks the hopper for one
// coin at a time and tracks how many coins of each value are left.
//
// Hopper handshake: entering EJECT raises exactly one eject_* request. That
// request stays high until a single-cycle hopper_ack is sampled in EJECT; on
// that edge the coin is considered paid. If no ack arrives within TIMEOUT
// EJECT cycles, the request is dropped, jam is raised and the payout is
// aborted. hopper_ack outside EJECT has no effect.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, change_amt     payout request; the amount is latched on accept
//   hopper_ack            hopper has ejected the requested coin
//   refill_en/sel/cnt     add refill_cnt coins to one inventory (sel 3 = none)
//   eject_25/10/5         one-hot coin eject requests
//   busy, done            payout in progress / one-cycle end-of-payout pulse
//   short, jam            ended with change owed / aborted on ack timeout
//   remaining             cents still owed
//   inv_25/10/5           current inventory counts (saturating)
// ---------------------------------------------------------------------------
module change_dispense_ctrl #(
    parameter int INV_W   = 6,
    parameter int INIT_25 = 20,
    parameter int INIT_10 = 20,
    parameter int INIT_5  = 20,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [7:0]       change_amt,
    input  logic             hopper_ack,
    input  logic             refill_en,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_cnt,
    output logic             eject_25,
    output logic             eject_10,
    output logic             eject_5,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic             jam,
    output logic [7:0]       remaining,
    output logic [INV_W-1:0] inv_25,
    output logic [INV_W-1:0] inv_10,
    output logic [INV_W-1:0] inv_5
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_EJECT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT-1: the last EJECT cycle is the
    // one in which the counter already holds TIMEOUT-1.
    localparam int               CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [INV_W-1:0] INV_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       ej25_d, ej10_d, ej5_d;
    logic       busy_d, done_d, short_d, jam_d;
    logic [7:0] rem_d;
    logic [7:0] coin_val;
    logic       dec_25, dec_10, dec_5;
    logic       add_25, add_10, add_5;

    // Refill plus a paid coin in the same cycle: inv + add - 1, clipped at
    // the counter maximum. A coin is only ever chosen while its count is
    // non-zero, so the decrement cannot go below zero; the guard is defensive.
    function automatic logic [INV_W-1:0] inv_next(
        input logic [INV_W-1:0] cur,
        input logic             add_en,
        input logic [INV_W-1:0] add,
        input logic             dec
    );
        logic [INV_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : {(INV_W+1){1'b0}});
        if (dec && (sum != '0)) begin
            sum = sum - (INV_W+1)'(1);
        end
        if (sum > {1'b0, INV_MAX}) begin
            return INV_MAX;
        end
        return sum[INV_W-1:0];
    endfunction

    assign add_25 = refill_en && (refill_sel == 2'd0);
    assign add_10 = refill_en && (refill_sel == 2'd1);
    assign add_5  = refill_en && (refill_sel == 2'd2);

    // The active request identifies the coin being paid.
    assign coin_val = eject_25 ? 8'd25 : (eject_10 ? 8'd10 : 8'd5);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ej25_d  = eject_25;
        ej10_d  = eject_10;
        ej5_d   = eject_5;
        busy_d  = busy;
        done_d  = 1'b0;
        short_d = short;
        jam_d   = jam;
        rem_d   = remaining;
        dec_25  = 1'b0;
        dec_10  = 1'b0;
        dec_5   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = change_amt;
                    short_d = 1'b0;
                    jam_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SELECT;
                end
            end

            S_SELECT: begin
                if (remaining == 8'd0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if ((remaining >= 8'd25) && (inv_25 != '0)) begin
                    ej25_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_EJECT;
                end else if ((remaining >= 8'd10) && (inv_10 != '0)) begin
                    ej10_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_EJECT;
                end else if ((remaining >= 8'd5) && (inv_5 != '0)) begin
                    ej5_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_EJECT;
                end else begin
                    // Nothing usable left (also covers non-multiples of 5).
                    short_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_EJECT: begin
                if (hopper_ack) begin
                    ej25_d  = 1'b0;
                    ej10_d  = 1'b0;
                    ej5_d   = 1'b0;
                    rem_d   = remaining - coin_val;
                    dec_25  = eject_25;
                    dec_10  = eject_10;
                    dec_5   = eject_5;
                    state_d = S_SELECT;
                end else if (cnt_q == TO_LAST) begin
                    ej25_d  = 1'b0;
                    ej10_d  = 1'b0;
                    ej5_d   = 1'b0;
                    jam_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs and inventories
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            eject_25  <= 1'b0;
            eject_10  <= 1'b0;
            eject_5   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            short     <= 1'b0;
            jam       <= 1'b0;
            remaining <= 8'd0;
            inv_25    <= INV_W'(INIT_25);
            inv_10    <= INV_W'(INIT_10);
            inv_5     <= INV_W'(INIT_5);
        end else begin
            cnt_q     <= cnt_d;
            eject_25  <= ej25_d;
            eject_10  <= ej10_d;
            eject_5   <= ej5_d;
            busy      <= busy_d;
            done      <= done_d;
            short     <= short_d;
            jam       <= jam_d;
            remaining <= rem_d;
            inv_25    <= inv_next(inv_25, add_25, refill_cnt, dec_25);
            inv_10    <= inv_next(inv_10, add_10, refill_cnt, dec_10);
            inv_5     <= inv_next(inv_5,  add_5,  refill_cnt, dec_5);
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Testbench for change_dispense_ctrl. A greedy payout model plans the coin
// sequence for each request into exp_q; a hopper driver acknowledges each
// request and compares the requested coin against the head of the queue.
module tb_change_dispense_ctrl;

    localparam int INV_W   = 6;
    localparam int INIT    = 20;
    localparam int TIMEOUT = 4;
    localparam int INV_MAX = 63;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [7:0]       change_amt;
    logic             hopper_ack;
    logic             refill_en;
    logic [1:0]       refill_sel;
    logic [INV_W-1:0] refill_cnt;
    logic             eject_25, eject_10, eject_5;
    logic             busy, done, short, jam;
    logic [7:0]       remaining;
    logic [INV_W-1:0] inv_25, inv_10, inv_5;

    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int m25, m10, m5;

    change_dispense_ctrl #(
        .INV_W(INV_W), .INIT_25(INIT), .INIT_10(INIT), .INIT_5(INIT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .change_amt(change_amt),
        .hopper_ack(hopper_ack), .refill_en(refill_en),
        .refill_sel(refill_sel), .refill_cnt(refill_cnt),
        .eject_25(eject_25), .eject_10(eject_10), .eject_5(eject_5),
        .busy(busy), .done(done), .short(short), .jam(jam),
        .remaining(remaining), .inv_25(inv_25), .inv_10(inv_10), .inv_5(inv_5)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > INV_MAX) ? INV_MAX : a + b;
    endfunction

    // Greedy reference: plans the coin sequence and updates the model
    // inventory. With no_ack only the first coin is requested and nothing is paid.
    task automatic model_plan(input int amt, input bit no_ack, output int rem, output bit shrt);
        rem  = amt;
        shrt = 1'b0;
        while (rem != 0) begin
            if (rem >= 25 && m25 > 0) begin
                exp_q.push_back(3'b100);
                if (no_ack) break;
                m25--; rem -= 25;
            end else if (rem >= 10 && m10 > 0) begin
                exp_q.push_back(3'b010);
                if (no_ack) break;
                m10--; rem -= 10;
            end else if (rem >= 5 && m5 > 0) begin
                exp_q.push_back(3'b001);
                if (no_ack) break;
                m5--; rem -= 5;
            end else begin
                shrt = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_inv(input string tag);
        check({tag, " inv_25"}, inv_25, m25);
        check({tag, " inv_10"}, inv_10, m10);
        check({tag, " inv_5"},  inv_5,  m5);
    endtask

    // ---------------- driver ----------------
    task automatic run_payout(input int amt, input bit no_ack, input int max_dly,
                              input bit do_refill, input bit poke_start);
        int rem_e, cyc, run_len, dly;
        bit short_e, first, finished, acked;
        logic [2:0] ej;
        model_plan(amt, no_ack, rem_e, short_e);

        @(negedge clk);
        start = 1'b1; change_amt = amt[7:0];
        @(negedge clk);
        start = 1'b0; change_amt = 8'($urandom);
        check("busy after start", busy, 1);

        cyc = 1; first = 1; finished = 0; acked = 0; run_len = 0;
        dly = $urandom_range(0, max_dly);
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            hopper_ack = 1'b0; refill_en = 1'b0; start = 1'b0;
            ej = {eject_25, eject_10, eject_5};
            if (acked) begin
                check("eject drops after ack", ej, 0);
                acked = 0;
            end
            if (poke_start && cyc == 3) begin
                start = 1'b1; change_amt = 8'd95;
            end
            if (ej != 3'b000) begin
                check("one-hot eject", $countones(ej), 1);
                if (first) begin
                    check("first eject latency", cyc, 2);
                    first = 0;
                end
                if (run_len == 0) begin
                    if (exp_q.size() == 0) check("unexpected eject", ej, 0);
                    else check("coin choice", ej, exp_q.pop_front());
                end
                run_len++;
                if (!no_ack && run_len > dly) begin
                    hopper_ack = 1'b1; acked = 1; run_len = 0;
                    dly = $urandom_range(0, max_dly);
                    if (do_refill) begin
                        refill_en = 1'b1; refill_sel = 2'd0; refill_cnt = 6'd5;
                        m25 = sat_add(m25, 5);
                    end
                end
            end
            if (done) begin
                finished = 1;
                check("busy low at done", busy, 0);
                check("remaining at done", remaining, rem_e);
                check("short at done", short, short_e);
                check("jam at done", jam, no_ack);
                check("coins left unrequested", exp_q.size(), 0);
                if (no_ack) check("jam eject length", run_len, TIMEOUT);
                if (amt == 0) begin
                    check("zero amount done latency", cyc, 2);
                    check("zero amount no eject", first, 1);
                end
                check_inv("done");
            end
        end
        if (!finished) check("done within budget", 0, 1);
        hopper_ack = 1'b0; refill_en = 1'b0; start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("done single cycle", done, 0);
    endtask

    // ---------------- main ----------------
    initial begin
        bit seen;
        reset_n = 1'b0; start = 1'b0; change_amt = 8'd0; hopper_ack = 1'b0;
        refill_en = 1'b0; refill_sel = 2'd0; refill_cnt = '0;
        m25 = INIT; m10 = INIT; m5 = INIT;
        repeat (3) @(negedge clk);
        check("reset ejects", {eject_25, eject_10, eject_5}, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset short", short, 0);
        check("reset jam", jam, 0);
        check("reset remaining", remaining, 0);
        check_inv("reset");
        reset_n = 1'b1;

        run_payout(40, 0, 0, 0, 0);                  // 25, 10, 5
        run_payout(0, 0, 0, 0, 0);                   // immediate done
        run_payout(7, 0, 0, 0, 0);                   // 5, then short with 2
        check("short remainder", remaining, 2);
        run_payout(225, 0, 2, 0, 0);                 // nine quarters -> 10 left
        run_payout(25, 0, 0, 1, 0);                  // refill on the ack cycle
        check("refill with decrement", inv_25, 14);
        run_payout(25, 1, 0, 0, 0);                  // jam, nothing paid
        check("jam keeps remaining", remaining, 25);
        run_payout(30, 0, 1, 0, 1);                  // clears jam; start while busy ignored

        // Ack while idle and a no-op refill select change nothing.
        @(negedge clk);
        hopper_ack = 1'b1; refill_en = 1'b1; refill_sel = 2'd3; refill_cnt = 6'd9;
        @(negedge clk);
        hopper_ack = 1'b0; refill_en = 1'b0;
        @(negedge clk);
        check_inv("idle ack/noop refill");
        check("idle busy", busy, 0);

        while (m25 > 0) run_payout(25, 0, 1, 0, 0);
        run_payout(30, 0, 1, 0, 0);                  // three dimes
        while (m5 > 0) run_payout(5, 0, 1, 0, 0);
        while (m10 > 1) run_payout(10, 0, 1, 0, 0);
        run_payout(30, 0, 0, 0, 0);                  // one dime, short
        check("short flag held", short, 1);
        check("short remaining 20", remaining, 20);

        // Saturating refill of dimes.
        repeat (2) begin
            @(negedge clk);
            refill_en = 1'b1; refill_sel = 2'd1; refill_cnt = 6'd63;
            m10 = sat_add(m10, 63);
        end
        @(negedge clk);
        refill_en = 1'b0;
        check("refill saturation", inv_10, INV_MAX);

        // Reset in the middle of an eject.
        @(negedge clk);
        refill_en = 1'b1; refill_sel = 2'd0; refill_cnt = 6'd2;
        @(negedge clk);
        refill_en = 1'b0; start = 1'b1; change_amt = 8'd25;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (eject_25) seen = 1;
        end
        check("eject before reset", seen, 1);
        #2 reset_n = 1'b0;
        #1;
        m25 = INIT; m10 = INIT; m5 = INIT;
        check("async reset ejects", {eject_25, eject_10, eject_5}, 0);
        check("async reset busy", busy, 0);
        check_inv("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no done after reset", done, 0);
        end

        run_payout(40, 0, 2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
- Sequences the coin-return hoppers after a vend completes.
- Takes a change amount in cents, picks coins greedily (25, then 10, then 5), and issues one eject request at a time to the hopper mechanism, using a request/acknowledge handshake.
- Keeps a per-denomination inventory count and flags when exact change cannot be paid.
- Flags a jammed hopper when an acknowledge does not arrive within a timeout.

Parameters:
- INV_W, 6, width of each inventory counter; counters saturate at 2^INV_W-1.
- INIT_25, 20, inventory of 25c coins loaded at reset.
- INIT_10, 20, inventory of 10c coins loaded at reset.
- INIT_5, 20, inventory of 5c coins loaded at reset.
- TIMEOUT, 255, number of EJECT cycles without an acknowledge before a jam is declared; must be at least 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to pay out change_amt
- change_amt  in  8  change owed in cents, sampled when start is accepted
- hopper_ack  in  1  single-cycle pulse: the hopper has ejected the requested coin
- refill_en  in  1  add refill_cnt to the inventory selected by refill_sel
- refill_sel  in  2  0=25c, 1=10c, 2=5c; 3=no-op
- refill_cnt  in  INV_W  number of coins to add
- eject_25  out  1  request to eject one 25c coin
- eject_10  out  1  request to eject one 10c coin
- eject_5  out  1  request to eject one 5c coin
- busy  out  1  payout in progress
- done  out  1  one-cycle pulse when a payout ends
- short  out  1  payout ended with change still owed because no usable coin remained
- jam  out  1  payout aborted on an acknowledge timeout
- remaining  out  8  cents still owed
- inv_25, inv_10, inv_5  out  INV_W each  current inventory counts

Behaviour:
- Reset (async, reset_n=0):
  - State is IDLE.
  - All eject_* outputs, busy, done, short and jam are 0; remaining is 0.
  - inv_25, inv_10 and inv_5 load INIT_25, INIT_10 and INIT_5.
- All outputs are registered. At most one eject_* is high at any time.
- States: IDLE, SELECT, EJECT, DONE.
- IDLE:
  - start=1: latch remaining=change_amt, clear short and jam, go to SELECT. busy=1 from the next cycle.
  - start=0: hold.
- SELECT (one cycle):
  - remaining==0: go to DONE.
  - Otherwise choose the first match in this order:
    - remaining>=25 and inv_25>0: 25c
    - remaining>=10 and inv_10>0: 10c
    - remaining>=5 and inv_5>0: 5c
  - Coin chosen: go to EJECT, clear the timeout counter, and assert the matching eject_* in the same cycle the EJECT state is entered.
  - No coin chosen (including remaining<5, e.g. a non-multiple of 5): set short=1 and go to DONE.
- EJECT:
  - eject_* is held high; the timeout counter increments each cycle.
  - hopper_ack=1:
    - deassert eject_*;
    - remaining -= coin value;
    - decrement that inventory count;
    - go to SELECT.
  - Counter reaches TIMEOUT with no ack: deassert eject_*, set jam=1, go to DONE; remaining and inventory are unchanged.
- DONE (one cycle): done=1 and busy=0. Go to IDLE next cycle. short and jam hold until the next accepted start.
- Latency:
  - start accepted at cycle N.
  - SELECT at N+1.
  - eject_* high at N+2.
  - ack at cycle M gives SELECT at M+1 and the next eject at M+2.
  - Ack on the first eject cycle is legal.
- Boundary and simultaneous-event rules:
  - start while not in IDLE: ignored, and change_amt is not re-sampled.
  - hopper_ack outside EJECT: ignored.
  - refill_en: applied every cycle in any state, saturating at 2^INV_W-1.
  - Refill and decrement of the same denomination in one cycle: net = inv + refill_cnt - 1, saturated.
  - A refill during SELECT is visible to the coin choice on the following SELECT, not the current one.
  - Reset mid-payout aborts immediately. No eject stays asserted and no done pulse is produced.

Test Plan:
- Default inventory, start with change_amt=40, ack 1 cycle after each request: eject_25, then eject_10, then eject_5, one at a time, each at least 2 cycles apart. Ends with remaining=0, done pulse, short=0, inv_25=19, inv_10=19, inv_5=19.
- start with change_amt=0: done pulse 2 cycles after start, no eject_* asserted, short=0.
- inv_25=0 (via parameter INIT_25=0), change_amt=30: three eject_10 requests, then done, inv_10=17. With inv_10=1 and inv_5=0, change_amt=30: one eject_10, then short=1, remaining=20, done pulse.
- change_amt=7, default inventory: one eject_5, then short=1, remaining=2.
- TIMEOUT=4, no ack: eject_25 high for exactly 4 cycles, then jam=1, done pulse, remaining=25, inv_25 unchanged. A subsequent start clears jam.
- Mid-payout:
  - refill_en with refill_sel=0 and refill_cnt=5 on the ack cycle of a 25c eject, from inv_25=10: inv_25 becomes 14.
  - start pulsed while busy: ignored.
  - reset_n asserted during EJECT: all eject_* fall asynchronously, inventories return to their INIT values.
